// File: rtl/dbus_io_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dbus_io_ctrl_pkg
// Shared constants for the data-bus I/O controller: I/O register map (both as
// 3-bit register indices and as full bus addresses), CTRL/STATUS bit
// positions, timer reset values and the read-select encoding.
// ---------------------------------------------------------------------------
package dbus_io_ctrl_pkg;

    // Address bit that steers an access to the I/O page instead of RAM.
    localparam int IO_SEL_BIT = 14;

    // I/O register indices (adr[2:0] within the I/O page).
    localparam logic [2:0] IO_GPIO_OUT  = 3'd0;
    localparam logic [2:0] IO_GPIO_IN   = 3'd1;
    localparam logic [2:0] IO_TIMER_CNT = 3'd2;
    localparam logic [2:0] IO_TIMER_CMP = 3'd3;
    localparam logic [2:0] IO_CTRL      = 3'd4;
    localparam logic [2:0] IO_STATUS    = 3'd5;

    // Full bus addresses of the I/O registers.
    localparam logic [15:0] ADDR_GPIO_OUT  = 16'h4000;
    localparam logic [15:0] ADDR_GPIO_IN   = 16'h4001;
    localparam logic [15:0] ADDR_TIMER_CNT = 16'h4002;
    localparam logic [15:0] ADDR_TIMER_CMP = 16'h4003;
    localparam logic [15:0] ADDR_CTRL      = 16'h4004;
    localparam logic [15:0] ADDR_STATUS    = 16'h4005;

    // CTRL and STATUS bit positions.
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_IRQ_EN_BIT  = 1;
    localparam int STATUS_MATCH_BIT = 0;

    localparam logic [15:0] TIMER_CMP_RESET = 16'hFFFF;

    // Which source drives dat_i for the read that completes next cycle.
    typedef enum logic {
        RD_SEL_RAM = 1'b0,
        RD_SEL_IO  = 1'b1
    } rd_sel_e;

    function automatic logic [15:0] pack_ctrl(input logic en, input logic irq_en);
        logic [15:0] v;
        v = '0;
        v[CTRL_EN_BIT]     = en;
        v[CTRL_IRQ_EN_BIT] = irq_en;
        return v;
    endfunction

    function automatic logic [15:0] pack_status(input logic match);
        logic [15:0] v;
        v = '0;
        v[STATUS_MATCH_BIT] = match;
        return v;
    endfunction

endpackage

// File: rtl/if_dbus.sv
// ---------------------------------------------------------------------------
// if_dbus
// Core data bus. adr is a 16-bit word address; re/we are single-cycle
// strobes; dat_o carries write data from the core; dat_i returns read data
// one cycle after re.
// ---------------------------------------------------------------------------
interface if_dbus;
    logic [15:0] adr;
    logic        re;
    logic        we;
    logic [15:0] dat_o;
    logic [15:0] dat_i;

    modport master (output adr, output re, output we, output dat_o, input dat_i);
    modport slave  (input adr, input re, input we, input dat_o, output dat_i);
endinterface

// File: rtl/dbus_io_ctrl_timer.sv
// ---------------------------------------------------------------------------
// io_timer
// 16-bit free-running compare timer with match flag and registered IRQ.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   wr_cnt/wr_cmp/
//   wr_ctrl/wr_status     one-cycle write strobes for the timer registers
//   wdata[15:0]           write data
//   cnt, cmp              current TIMER_CNT / TIMER_CMP
//   en, irq_en            CTRL bits
//   match                 STATUS.MATCH
//   irq                   registered MATCH & IRQ_EN
// ---------------------------------------------------------------------------
module io_timer
    import dbus_io_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_cnt,
    input  logic        wr_cmp,
    input  logic        wr_ctrl,
    input  logic        wr_status,
    input  logic [15:0] wdata,
    output logic [15:0] cnt,
    output logic [15:0] cmp,
    output logic        en,
    output logic        irq_en,
    output logic        match,
    output logic        irq
);

    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        match_q, match_d;
    logic        irq_q, irq_d;
    logic        hit;

    always_comb begin
        // A match is only recognised while the counter is running.
        hit = en_q && (cnt_q == cmp_q);

        cnt_d = cnt_q;
        if (hit) begin
            cnt_d = '0;
        end else if (en_q) begin
            cnt_d = cnt_q + 16'd1;
        end
        // Software write beats both increment and match reload.
        if (wr_cnt) begin
            cnt_d = wdata;
        end

        cmp_d    = wr_cmp  ? wdata                  : cmp_q;
        en_d     = wr_ctrl ? wdata[CTRL_EN_BIT]     : en_q;
        irq_en_d = wr_ctrl ? wdata[CTRL_IRQ_EN_BIT] : irq_en_q;

        // W1C first, then set, so a simultaneous set wins.
        match_d = match_q;
        if (wr_status && wdata[STATUS_MATCH_BIT]) begin
            match_d = 1'b0;
        end
        if (hit) begin
            match_d = 1'b1;
        end

        irq_d = match_q & irq_en_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            cmp_q    <= TIMER_CMP_RESET;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            match_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            match_q  <= match_d;
            irq_q    <= irq_d;
        end
    end

    assign cnt    = cnt_q;
    assign cmp    = cmp_q;
    assign en     = en_q;
    assign irq_en = irq_en_q;
    assign match  = match_q;
    assign irq    = irq_q;

endmodule

// File: rtl/dbus_io_ctrl.sv
// ---------------------------------------------------------------------------
// dbus_io_ctrl
// Data-bus address decoder: adr[14]=0 goes straight through to the data RAM,
// adr[14]=1 selects the I/O page (GPIO, timer). Reads return one cycle after
// re and dat_i holds the last read value until the next read completes.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   dbus              core data bus (slave side)
//   ram_adr/re/we/d   combinational RAM request; ram_q is RAM read data,
//                     valid one cycle after ram_re
//   gpio_o            GPIO output register
//   gpio_i            asynchronous GPIO inputs (double-synchronised)
//   irq               timer interrupt request
// ---------------------------------------------------------------------------
module dbus_io_ctrl
    import dbus_io_ctrl_pkg::*;
#(
    parameter int RAM_AW = 14
) (
    input  logic              clk,
    input  logic              reset,
    if_dbus.slave             dbus,
    output logic [RAM_AW-1:0] ram_adr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [15:0]       ram_d,
    input  logic [15:0]       ram_q,
    output logic [15:0]       gpio_o,
    input  logic [15:0]       gpio_i,
    output logic              irq
);

    logic        io_hit;
    logic [2:0]  io_idx;
    logic        io_wr;

    logic [15:0] gpio_o_q, gpio_o_d;
    logic [15:0] gpio_s1_q, gpio_s1_d;
    logic [15:0] gpio_s2_q, gpio_s2_d;

    rd_sel_e     rd_sel_q, rd_sel_d;
    logic        rd_pend_q, rd_pend_d;
    logic [15:0] io_rdata_q, io_rdata_d;
    logic [15:0] dat_hold_q, dat_hold_d;
    logic [15:0] io_rd_val;
    logic [15:0] rd_mux;

    logic [15:0] tmr_cnt, tmr_cmp;
    logic        tmr_en, tmr_irq_en, tmr_match;

    logic        unused_adr;

    // adr[15] and the bits between the RAM range and the register index
    // play no part in decode.
    assign unused_adr = ^dbus.adr;

    assign io_hit = dbus.adr[IO_SEL_BIT];
    assign io_idx = dbus.adr[2:0];
    assign io_wr  = dbus.we & io_hit;

    // RAM request is pure pass-through, untouched by reset.
    assign ram_adr = dbus.adr[RAM_AW-1:0];
    assign ram_d   = dbus.dat_o;
    assign ram_re  = dbus.re & ~io_hit;
    assign ram_we  = dbus.we & ~io_hit;

    io_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr_cnt    (io_wr && (io_idx == IO_TIMER_CNT)),
        .wr_cmp    (io_wr && (io_idx == IO_TIMER_CMP)),
        .wr_ctrl   (io_wr && (io_idx == IO_CTRL)),
        .wr_status (io_wr && (io_idx == IO_STATUS)),
        .wdata     (dbus.dat_o),
        .cnt       (tmr_cnt),
        .cmp       (tmr_cmp),
        .en        (tmr_en),
        .irq_en    (tmr_irq_en),
        .match     (tmr_match),
        .irq       (irq)
    );

    // I/O read value from current (pre-write) register state.
    always_comb begin
        io_rd_val = '0;
        case (io_idx)
            IO_GPIO_OUT:  io_rd_val = gpio_o_q;
            IO_GPIO_IN:   io_rd_val = gpio_s2_q;
            IO_TIMER_CNT: io_rd_val = tmr_cnt;
            IO_TIMER_CMP: io_rd_val = tmr_cmp;
            IO_CTRL:      io_rd_val = pack_ctrl(tmr_en, tmr_irq_en);
            IO_STATUS:    io_rd_val = pack_status(tmr_match);
            default:      io_rd_val = '0;
        endcase
    end

    always_comb begin
        gpio_o_d = gpio_o_q;
        if (io_wr && (io_idx == IO_GPIO_OUT)) begin
            gpio_o_d = dbus.dat_o;
        end
        gpio_s1_d = gpio_i;
        gpio_s2_d = gpio_s1_q;

        rd_pend_d  = dbus.re;
        rd_sel_d   = rd_sel_q;
        io_rdata_d = io_rdata_q;
        if (dbus.re) begin
            rd_sel_d = io_hit ? RD_SEL_IO : RD_SEL_RAM;
            if (io_hit) begin
                io_rdata_d = io_rd_val;
            end
        end

        // Capture the completing read so dat_i holds it afterwards, when
        // ram_q may already have moved on.
        dat_hold_d = rd_pend_q ? rd_mux : dat_hold_q;
    end

    assign rd_mux     = (rd_sel_q == RD_SEL_RAM) ? ram_q : io_rdata_q;
    assign dbus.dat_i = rd_pend_q ? rd_mux : dat_hold_q;
    assign gpio_o     = gpio_o_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_o_q   <= '0;
            gpio_s1_q  <= '0;
            gpio_s2_q  <= '0;
            rd_sel_q   <= RD_SEL_RAM;
            rd_pend_q  <= 1'b0;
            io_rdata_q <= '0;
            dat_hold_q <= '0;
        end else begin
            gpio_o_q   <= gpio_o_d;
            gpio_s1_q  <= gpio_s1_d;
            gpio_s2_q  <= gpio_s2_d;
            rd_sel_q   <= rd_sel_d;
            rd_pend_q  <= rd_pend_d;
            io_rdata_q <= io_rdata_d;
            dat_hold_q <= dat_hold_d;
        end
    end

endmodule
